// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock over WIDTH/DIGIT RUN cycles
module serial_addsub #(
   parameter int WIDTH = 9,
   parameter int DIGIT = 3
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Sub,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("WIDTH must be an integer multiple of DIGIT");
   end
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d, acc_sh;
   logic [CW-1:0] cnt_q, cnt_d;
   logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
   logic [DIGIT:0] sum;
   logic c_msb;
   always_comb begin
      sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
      // carry into the top bit of this digit, recovered from its sum bit
      c_msb = sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
      acc_sh = WIDTH'({sum[DIGIT-1:0], acc_q} >> DIGIT);
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      s_d = s_q;
      cout_d = cout_q;
      ovf_d = ovf_q;
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_q == IDLE && Start) begin
         state_d = RUN;
         a_d = A;
         b_d = B ^ {WIDTH{Sub}};
         c_d = Sub | Cin;
         cnt_d = '0;
         busy_d = 1'b1;
      end else if (state_q == RUN) begin
         a_d = a_q >> DIGIT;
         b_d = b_q >> DIGIT;
         c_d = sum[DIGIT];
         acc_d = acc_sh;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = DONE;
            s_d = acc_sh;
            cout_d = sum[DIGIT];
            ovf_d = c_msb ^ sum[DIGIT];
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         c_q <= 1'b0;
         acc_q <= '0;
         cnt_q <= '0;
         s_q <= '0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         s_q <= s_d;
         cout_q <= cout_d;
         ovf_q <= ovf_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign Busy = busy_q;
   assign Done = done_q;
   assign S = s_q;
   assign Cout = cout_q;
   assign Ovf = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors and random model compare across 9/3, 8/1 and 8/8 configurations
module tb_serial_addsub;
   logic Clk = 1'b0, Reset_n = 1'b0, sub = 1'b0, cin = 1'b0;
   logic [2:0] st = '0;
   logic [8:0] a = '0, b = '0;
   logic [2:0] busy_w, done_w, cout_w, ovf_w;
   logic [8:0] s0;
   logic [7:0] s1, s2;
   int n_chk = 0, n_fail = 0;
   typedef struct {
      int d;
      logic sub;
      logic cin;
      logic [8:0] a;
      logic [8:0] b;
      int s;
      int cout;
      int ovf;
   } vec_t;
   vec_t tv [9];
   always #5 Clk = ~Clk;
   serial_addsub #(.WIDTH(9), .DIGIT(3)) u0 (.Clk(Clk), .Reset_n(Reset_n), .Start(st[0]), .Sub(sub), .Cin(cin),
      .A(a), .B(b), .Busy(busy_w[0]), .Done(done_w[0]), .S(s0), .Cout(cout_w[0]), .Ovf(ovf_w[0]));
   serial_addsub #(.WIDTH(8), .DIGIT(1)) u1 (.Clk(Clk), .Reset_n(Reset_n), .Start(st[1]), .Sub(sub), .Cin(cin),
      .A(a[7:0]), .B(b[7:0]), .Busy(busy_w[1]), .Done(done_w[1]), .S(s1), .Cout(cout_w[1]), .Ovf(ovf_w[1]));
   serial_addsub #(.WIDTH(8), .DIGIT(8)) u2 (.Clk(Clk), .Reset_n(Reset_n), .Start(st[2]), .Sub(sub), .Cin(cin),
      .A(a[7:0]), .B(b[7:0]), .Busy(busy_w[2]), .Done(done_w[2]), .S(s2), .Cout(cout_w[2]), .Ovf(ovf_w[2]));
   function automatic int lat(input int d);
      return d == 0 ? 3 : (d == 1 ? 8 : 1);
   endfunction
   function automatic int wd(input int d);
      return d == 0 ? 9 : 8;
   endfunction
   function automatic int s_of(input int d);
      return d == 0 ? int'(s0) : (d == 1 ? int'(s1) : int'(s2));
   endfunction
   // returns {ovf, cout, s} packed at bit positions w+1, w, w-1:0
   function automatic int model(input int w, input logic sb, input logic ci, input int av, input int bv);
      int mask, bb, full, s, ov;
      mask = (1 << w) - 1;
      bb = sb ? (~bv & mask) : (bv & mask);
      full = (av & mask) + bb + (sb ? 1 : int'(ci));
      s = full & mask;
      ov = (((av >> (w - 1)) & 1) == ((bb >> (w - 1)) & 1) && ((s >> (w - 1)) & 1) != ((av >> (w - 1)) & 1)) ? 1 : 0;
      return (ov << (w + 1)) | (full & ((mask << 1) | 1));
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic op(input string name, input int d, input logic sb, input logic ci, input logic [8:0] av,
                     input logic [8:0] bv, input int es, input int ec, input int eo);
      int n;
      n = 0;
      a = av;
      b = bv;
      sub = sb;
      cin = ci;
      st[d] = 1'b1;
      @(negedge Clk);
      st[d] = 1'b0;
      chk({name, " busy"}, int'(busy_w[d]), 1);
      while (!done_w[d] && n < 20) begin
         @(negedge Clk);
         n++;
      end
      chk({name, " latency"}, n, lat(d));
      chk({name, " busy at done"}, int'(busy_w[d]), 0);
      chk({name, " s"}, s_of(d), es);
      chk({name, " cout"}, int'(cout_w[d]), ec);
      chk({name, " ovf"}, int'(ovf_w[d]), eo);
      @(negedge Clk);
      chk({name, " done pulse"}, int'(done_w[d]), 0);
   endtask
   initial begin
      int dn, e, w;
      logic [8:0] ra, rb;
      logic rs, rc;
      tv[0] = '{0, 1'b0, 1'b0, 9'h0FF, 9'h001, 'h100, 0, 1};
      tv[1] = '{0, 1'b0, 1'b0, 9'h1FF, 9'h001, 'h000, 1, 0};
      tv[2] = '{0, 1'b0, 1'b1, 9'h1FF, 9'h001, 'h001, 1, 0};
      tv[3] = '{0, 1'b1, 1'b1, 9'h005, 9'h007, 'h1FE, 0, 0};
      tv[4] = '{0, 1'b1, 1'b0, 9'h100, 9'h001, 'h0FF, 1, 1};
      tv[5] = '{1, 1'b0, 1'b1, 9'h0FF, 9'h001, 'h01, 1, 0};
      tv[6] = '{2, 1'b0, 1'b1, 9'h0FF, 9'h001, 'h01, 1, 0};
      tv[7] = '{1, 1'b1, 1'b0, 9'h080, 9'h001, 'h7F, 1, 1};
      tv[8] = '{2, 1'b0, 1'b0, 9'h07F, 9'h001, 'h80, 0, 1};
      repeat (3) @(negedge Clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset%0d busy", d), int'(busy_w[d]), 0);
         chk($sformatf("reset%0d done", d), int'(done_w[d]), 0);
         chk($sformatf("reset%0d s", d), s_of(d), 0);
         chk($sformatf("reset%0d cout", d), int'(cout_w[d]), 0);
         chk($sformatf("reset%0d ovf", d), int'(ovf_w[d]), 0);
      end
      Reset_n = 1'b1;
      @(negedge Clk);
      for (int i = 0; i < 9; i++)
         op($sformatf("tv%0d", i), tv[i].d, tv[i].sub, tv[i].cin, tv[i].a, tv[i].b, tv[i].s, tv[i].cout, tv[i].ovf);
      a = 9'h003;
      b = 9'h004;
      sub = 1'b0;
      cin = 1'b0;
      st[0] = 1'b1;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         dn += int'(done_w[0]);
         if (i == 0) begin
            a = 9'h1FF;
            b = 9'h1FF;
            sub = 1'b1;
            cin = 1'b1;
         end
         if (i == 4) st[0] = 1'b0;
      end
      chk("ignore done count", dn, 1);
      chk("ignore s", int'(s0), 'h007);
      chk("ignore cout", int'(cout_w[0]), 0);
      chk("ignore busy", int'(busy_w[0]), 0);
      a = 9'h0AA;
      b = 9'h011;
      sub = 1'b0;
      st[0] = 1'b1;
      @(negedge Clk);
      st[0] = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      chk("midrun busy", int'(busy_w[0]), 0);
      chk("midrun done", int'(done_w[0]), 0);
      chk("midrun s", int'(s0), 0);
      chk("midrun cout", int'(cout_w[0]), 0);
      op("after reset", 0, 1'b0, 1'b0, 9'h0AA, 9'h011, 'h0BB, 0, 0);
      dn = 0;
      repeat (5) begin
         @(negedge Clk);
         dn += int'(done_w[0]);
      end
      chk("no stray done", dn, 0);
      Reset_n = 1'b0;
      st[0] = 1'b1;
      @(negedge Clk);
      Reset_n = 1'b1;
      st[0] = 1'b0;
      chk("reset beats start", int'(busy_w[0]), 0);
      for (int d = 0; d < 3; d++) begin
         w = wd(d);
         for (int i = 0; i < 15; i++) begin
            ra = 9'($urandom);
            rb = 9'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            e = model(w, rs, rc, int'(ra), int'(rb));
            op($sformatf("rnd d%0d #%0d", d, i), d, rs, rc, ra, rb, e & ((1 << w) - 1), (e >> w) & 1, (e >> (w + 1)) & 1);
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 9: operand and result width in bits.
REQ-002 Parameter DIGIT, default 3: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT (N = WIDTH/DIGIT); violation SHALL fail elaboration.
REQ-003 Clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Reset_n  input  1  synchronous, active-low reset.
REQ-005 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Sub  input  1  0 = add, 1 = subtract; sampled with Start.
REQ-007 Cin  input  1  carry-in for add; ignored when Sub = 1; sampled with Start.
REQ-008 A  input  WIDTH  first operand; sampled with Start.
REQ-009 B  input  WIDTH  second operand; sampled with Start.
REQ-010 Busy  output  1  high while in RUN.
REQ-011 Done  output  1  one-cycle pulse; result valid.
REQ-012 S  output  WIDTH  result, registered.
REQ-013 Cout  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-014 Ovf  output  1  two's-complement signed overflow.

Function
REQ-015 States: IDLE, RUN, DONE; all outputs SHALL be driven from registers.
REQ-016 IDLE: Start = 1 at an edge latches A, B XOR {WIDTH{Sub}}, and carry register = Sub ? 1 : Cin; zeroes the digit counter; moves to RUN.
REQ-017 IDLE with Start = 0: remain IDLE; S, Cout, Ovf hold their last values.
REQ-018 RUN: each edge adds the low DIGIT bits of both latched operands plus the carry register; writes the DIGIT sum bits into the result shift register (LSB digit first); updates the carry; shifts the operands right by DIGIT; increments the counter.
REQ-019 RUN: lasts exactly N edges; at the Nth edge, S = full result, Cout = final carry, Ovf = (carry into MSB) XOR (carry out of MSB); state moves to DONE.
REQ-020 Arithmetic: add gives {Cout,S} = A + B + Cin; subtract gives {Cout,S} = A + ~B + 1, all modulo 2^(WIDTH+1).
REQ-021 DONE: Done = 1 and Busy = 0 for exactly one cycle; the next edge moves to IDLE unconditionally.
REQ-022 Latency: Start sampled at edge k; Done high in the cycle after edge k+N; Busy high in the cycles after edges k .. k+N-1.
REQ-023 Start asserted in RUN or DONE SHALL be ignored: no restart and no queuing, and the in-flight result is unaffected.
REQ-024 A, B, Sub and Cin changing after the Start edge SHALL NOT affect the in-flight result.
REQ-025 Intermediate digits SHALL NOT be visible on S: S updates only at the Nth RUN edge, from a separate shift register.
REQ-026 DIGIT = WIDTH (N = 1) SHALL be legal: one RUN cycle.

Reset
REQ-027 Reset_n = 0 at an edge forces IDLE in any state, including mid-RUN, and sets S = 0, Cout = 0, Ovf = 0, Busy = 0, Done = 0, counter = 0, carry = 0.
REQ-028 Reset_n SHALL take priority over Start on the same edge.
REQ-029 After Reset_n returns high, a Start on the next edge SHALL be accepted normally.

Verification
REQ-030 WIDTH = 9, DIGIT = 3: A = 0x0FF, B = 0x001, Sub = 0, Cin = 0 -> Done 3 cycles after Start; S = 0x100, Cout = 0, Ovf = 1.
REQ-031 A = 0x1FF, B = 0x001, add, Cin = 0 -> S = 0x000, Cout = 1, Ovf = 0; the same operands with Cin = 1 -> S = 0x001, Cout = 1.
REQ-032 Sub = 1, A = 0x005, B = 0x007, Cin = 1 (ignored) -> S = 0x1FE, Cout = 0, Ovf = 0; A = 0x100, B = 0x001 -> S = 0x0FF, Cout = 1, Ovf = 1.
REQ-033 Start A = 0x003, B = 0x004 (add), then Start A = 0x1FF, B = 0x1FF while Busy -> exactly one Done pulse, S = 0x007; a new operation is accepted only after return to IDLE.
REQ-034 Reset_n low for one edge during the second RUN cycle -> next cycle Busy = 0, Done = 0, S = 0; no Done pulse follows; a Start issued afterwards completes correctly.
REQ-035 WIDTH = 8, DIGIT = 1 and WIDTH = 8, DIGIT = 8: A = 0xFF, B = 0x01, Cin = 1 -> S = 0x01, Cout = 1, Done after 8 and 1 cycles respectively; a random compare against an A+B+Cin model runs in both configurations.
